fifo2axi: RTL and testbench
===========================

Name: fifo2axi

Overview:
- AXI4 slave read responder that drains a native first-word-fall-through (FWFT) FIFO onto the AXI4 read channels.
- It is the read-back counterpart of the AXI4-write-to-FIFO path: data produced by the RTO core (timestamps, captured samples) is collected by the PS over AXI.
- Each beat of a read burst to the data address pops one 128-bit FIFO word.
- A status address returns flags and a pop counter without popping.

Parameters:
- AXI_ADDR_WIDTH, 6, read address width.
- AXI_DATA_WIDTH, 128, read data width; equals FIFO word width.
- TIMEOUT_CYCLES, 1024, empty-FIFO wait limit per beat; used only with FIFO2AXI_TIMEOUT_EN.

Ports:
- s_axi_aclk  in  1  single clock for all logic.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axi_arburst  in  2  ignored; the address is fixed for every beat.
- s_axi_arsize  in  3  ignored; every beat is full width.
- s_axi_arlen  in  8  burst length minus 1.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready (combinational).
- s_axi_rready  in  1  R ready.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data (registered).
- s_axi_rresp  out  2  read response (registered).
- s_axi_rvalid  out  1  R valid (registered).
- s_axi_rlast  out  1  last beat of burst (registered).
- fifo_dout  in  AXI_DATA_WIDTH  FWFT head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_full  in  1  FIFO full (status only).
- fifo_rd_en  out  1  pop strobe (combinational, one cycle per beat).

Behaviour:
- Reset values:
  - state=IDLE; s_axi_rvalid=0, s_axi_rlast=0, s_axi_rresp=0, s_axi_rdata=0.
  - beat counter=0, pop counter=0, timeout counter=0.
  - fifo_rd_en=0.
- Reset mid-burst: abandon the burst immediately, issue no pop, return to IDLE. The next AR is accepted normally.
- Address map:
  - 0x00 is DATA (pop per beat).
  - 0x10 is STATUS.
  - Any other address is DECODE_ERR.
- s_axi_arready = (state==IDLE).
- AR handshake (arvalid & arready):
  - Latch the address class.
  - beats_left = arlen.
  - Go to READ_FIFO, READ_STATUS or READ_ERROR.
- Beat load condition: (rvalid==0 or rready==1), the burst is not finished, and the state-specific condition holds.
- On a beat load, the block registers rdata/rresp and sets rvalid=1 and rlast=(beats_left==0).
- When the final beat (rlast=1) completes with rvalid & rready and no further load occurs, set rvalid=0 and rlast=0, then return to IDLE.
- Latency: the first rvalid appears no earlier than the 2nd rising edge after the AR handshake. Beats then stream back-to-back, one per cycle, while rready=1 and data is available.
- rvalid, rdata, rresp and rlast hold stable while rvalid=1 and rready=0.
- READ_FIFO:
  - Load only when fifo_empty=0.
  - fifo_rd_en=1 in the same cycle as the load, and only then; rdata=fifo_dout, rresp=OKAY (00).
  - Pop counter increments by 1 per pop (32 bit, wraps 0xFFFFFFFF to 0).
  - If the FIFO is empty, wait; no beat is produced.
- READ_STATUS:
  - Every beat loads immediately; no pop.
  - rdata = {64'b0, pop_count[31:0], 30'b0, fifo_full, fifo_empty}, sampled at load; rresp=OKAY.
- READ_ERROR:
  - Produces arlen+1 beats; rdata=0, rresp=DECERR (11); no pop.
- beats_left decrements on each load. The full range arlen=255 (256 beats) is supported.
- An AR presented during a burst is held off (arready=0) until IDLE.
- fifo_full is never used for flow control.

Optional Feature:
- Macro FIFO2AXI_TIMEOUT_EN.
- When defined, in READ_FIFO a per-beat counter counts cycles with a pending beat and fifo_empty=1.
  - When the counter reaches TIMEOUT_CYCLES, the block loads a beat with rdata=0, rresp=SLVERR (10) and no pop.
  - The counter clears on every load. The burst continues with the remaining beats.
- When undefined, there is no counter and the block waits on an empty FIFO indefinitely.

Test Plan:
- DATA burst: FIFO preloaded with words 0x1..0x4, AR addr=0x00, arlen=3, rready=1 → four beats 0x1,0x2,0x3,0x4 back-to-back, rresp=00, rlast only on beat 4, exactly 4 fifo_rd_en pulses, status pop_count=4.
- Backpressure: same burst with rready toggling 1,0,0,1… → rdata held stable while rready=0, no extra pops, order preserved.
- Empty stall: FIFO empty, AR 0x00 arlen=0 → no rvalid.
  - Push 0xABCD after 50 cycles → single beat 0xABCD with rlast=1.
  - With FIFO2AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no push → after 16 cycles, beat rdata=0, rresp=10.
- STATUS/DECERR: AR 0x10 arlen=1 with FIFO full → two beats with bit1=1, bit0=0, no pop. AR 0x20 arlen=2 → three beats rresp=11, rdata=0.
- Reset mid-burst: assert s_axi_areset during beat 2 of an arlen=7 DATA burst → next cycle rvalid=0, arready=1, pop_count=0, no pop during reset. A new arlen=0 burst completes correctly.

Source files
------------

// File: rtl/fifo2axi_if.sv
// Bus bundle for fifo2axi: AXI4 read address/data channels plus the FWFT FIFO read port.
// The slave modport is the responder's view; master is the AXI master + FIFO owner.
interface fifo2axi_if #(
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 128
);
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic [1:0]                s_axi_arburst;
  logic [2:0]                s_axi_arsize;
  logic [7:0]                s_axi_arlen;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic                      s_axi_rready;
  logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rlast;
  logic [AXI_DATA_WIDTH-1:0] fifo_dout;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_rd_en;

  modport slave (
    input  s_axi_araddr, s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    input  s_axi_rready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast,
    input  fifo_dout, fifo_empty, fifo_full,
    output fifo_rd_en
  );

  modport master (
    output s_axi_araddr, s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    output s_axi_rready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast,
    output fifo_dout, fifo_empty, fifo_full,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo2axi.sv
// fifo2axi: AXI4 read responder that pops one FWFT FIFO word per DATA beat and serves a STATUS word.
// Optional per-beat empty-FIFO timeout (SLVERR beat) is enabled by defining FIFO2AXI_TIMEOUT_EN.
module fifo2axi #(
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic      s_axi_aclk,
  input  logic      s_axi_areset,
  fifo2axi_if.slave bus
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_DATA   = '0;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STATUS = AXI_ADDR_WIDTH'(16);

  typedef enum logic [1:0] {IDLE, READ_FIFO, READ_STATUS, READ_ERROR} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                beats_left_q, beats_left_d;
  logic [31:0]               pop_cnt_q, pop_cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      can_load;
  logic                      load;
  logic                      pop;
  logic [63:0]               status_word;
  logic                      unused_ar_fields;

`ifdef FIFO2AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Burst type and size do not change behaviour: every beat reuses the same address, full width.
  assign unused_ar_fields = ^{bus.s_axi_arburst, bus.s_axi_arsize};

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    pop_cnt_d    = pop_cnt_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    load         = 1'b0;
    pop          = 1'b0;
`ifdef FIFO2AXI_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    // rlast_q marks that the final beat is already loaded, so no further loads are allowed.
    can_load    = (state_q != IDLE) && (!rvalid_q || bus.s_axi_rready) && !rlast_q;
    status_word = {pop_cnt_q, 30'b0, bus.fifo_full, bus.fifo_empty};

    unique case (state_q)
      IDLE: begin
        if (bus.s_axi_arvalid) begin
          beats_left_d = bus.s_axi_arlen;
          rlast_d      = 1'b0;
          if (bus.s_axi_araddr == ADDR_DATA) begin
            state_d = READ_FIFO;
          end else if (bus.s_axi_araddr == ADDR_STATUS) begin
            state_d = READ_STATUS;
          end else begin
            state_d = READ_ERROR;
          end
        end
      end
      READ_FIFO: begin
        if (can_load) begin
          if (!bus.fifo_empty) begin
            load    = 1'b1;
            pop     = 1'b1;
            rdata_d = bus.fifo_dout;
            rresp_d = RESP_OKAY;
          end
`ifdef FIFO2AXI_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            load    = 1'b1;
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
`endif
        end
      end
      READ_STATUS: begin
        if (can_load) begin
          load    = 1'b1;
          rdata_d = AXI_DATA_WIDTH'(status_word);
          rresp_d = RESP_OKAY;
        end
      end
      READ_ERROR: begin
        if (can_load) begin
          load    = 1'b1;
          rdata_d = '0;
          rresp_d = RESP_DECERR;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      rvalid_d     = 1'b1;
      rlast_d      = (beats_left_q == 8'd0);
      beats_left_d = beats_left_q - 8'd1;
`ifdef FIFO2AXI_TIMEOUT_EN
      tmo_cnt_d    = '0;
`endif
    end else if (rvalid_q && bus.s_axi_rready) begin
      rvalid_d = 1'b0;
      if (rlast_q) begin
        rlast_d = 1'b0;
        state_d = IDLE;
      end
    end

    if (pop) begin
      pop_cnt_d = pop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      pop_cnt_q    <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
`ifdef FIFO2AXI_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      pop_cnt_q    <= pop_cnt_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
`ifdef FIFO2AXI_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.s_axi_arready = (state_q == IDLE);
  // A reset abandons the burst, so the FIFO must not lose a word in that cycle.
  assign bus.fifo_rd_en    = pop && !s_axi_areset;
  assign bus.s_axi_rvalid  = rvalid_q;
  assign bus.s_axi_rlast   = rlast_q;
  assign bus.s_axi_rresp   = rresp_q;
  assign bus.s_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_fifo2axi.sv
// Directed self-checking bench for fifo2axi with a small FWFT FIFO model and an R-channel monitor.
module tb_fifo2axi;
`ifdef FIFO2AXI_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    int           cyc;
  } beat_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pops = 0;
  int   rd_ptr = 0;
  int   wr_ptr = 0;
  logic full_flag = 1'b0;
  logic [127:0] mem [16];
  beat_t beats [$];
  beat_t mon_beat;
  logic hold_pend = 1'b0;
  logic [127:0] hold_data;
  logic [1:0] hold_resp;
  logic hold_last;

  fifo2axi_if #(.AXI_ADDR_WIDTH(6), .AXI_DATA_WIDTH(128)) bus ();

  fifo2axi #(
    .AXI_ADDR_WIDTH(6),
    .AXI_DATA_WIDTH(128),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(srst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_dout  = mem[rd_ptr % 16];
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_full  = full_flag;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      check("pop_nonempty", {127'b0, bus.fifo_empty}, 128'd0);
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  // R-channel monitor: records completed beats and checks stability under backpressure.
  always @(negedge clk) begin
    if (hold_pend) begin
      check("hold_valid", {127'b0, bus.s_axi_rvalid}, 128'd1);
      check("hold_data", bus.s_axi_rdata, hold_data);
      check("hold_resp", {126'b0, bus.s_axi_rresp}, {126'b0, hold_resp});
      check("hold_last", {127'b0, bus.s_axi_rlast}, {127'b0, hold_last});
    end
    if (bus.s_axi_rvalid && bus.s_axi_rready && !srst) begin
      mon_beat.data = bus.s_axi_rdata;
      mon_beat.resp = bus.s_axi_rresp;
      mon_beat.last = bus.s_axi_rlast;
      mon_beat.cyc  = cyc;
      beats.push_back(mon_beat);
      $display("beat %0d data=%h resp=%0d last=%0b", beats.size(), mon_beat.data,
               mon_beat.resp, mon_beat.last);
    end
    hold_pend = bus.s_axi_rvalid && !bus.s_axi_rready && !srst;
    hold_data = bus.s_axi_rdata;
    hold_resp = bus.s_axi_rresp;
    hold_last = bus.s_axi_rlast;
  end

  task automatic push(input logic [127:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic ar_req(input logic [5:0] a, input logic [7:0] len);
    int k = 0;
    bus.s_axi_araddr  = a;
    bus.s_axi_arlen   = len;
    bus.s_axi_arvalid = 1'b1;
    while (!bus.s_axi_arready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ar_ready", {127'b0, bus.s_axi_arready}, 128'd1);
    @(posedge clk); #1;
    bus.s_axi_arvalid = 1'b0;
    $display("ar addr=%h len=%0d", a, len);
    check("first_beat_latency", {127'b0, bus.s_axi_rvalid}, 128'd0);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("beat_count", 128'(beats.size()), 128'(n));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!bus.s_axi_arready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("back_to_idle", {127'b0, bus.s_axi_arready}, 128'd1);
    check("idle_rvalid", {127'b0, bus.s_axi_rvalid}, 128'd0);
  endtask

  task automatic check_beat(input int idx, input logic [127:0] d, input logic [1:0] r,
                            input logic l);
    if (idx < beats.size()) begin
      check($sformatf("beat%0d_data", idx), beats[idx].data, d);
      check($sformatf("beat%0d_resp", idx), {126'b0, beats[idx].resp}, {126'b0, r});
      check($sformatf("beat%0d_last", idx), {127'b0, beats[idx].last}, {127'b0, l});
    end else begin
      check("beat_present", 128'(beats.size()), 128'(idx + 1));
    end
  endtask

  task automatic read_status(input logic [127:0] exp);
    beats.delete();
    ar_req(6'h10, 8'd0);
    wait_beats(1, 10);
    check_beat(0, exp, 2'b00, 1'b1);
    wait_idle();
  endtask

  initial begin
    int p0;
    int c0;
    int k;
    logic saw;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arburst = 2'b01;
    bus.s_axi_arsize  = 3'd4;
    bus.s_axi_arlen   = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", {127'b0, bus.s_axi_rvalid}, 128'd0);
    check("rst_rlast", {127'b0, bus.s_axi_rlast}, 128'd0);
    check("rst_rresp", {126'b0, bus.s_axi_rresp}, 128'd0);
    check("rst_rdata", bus.s_axi_rdata, 128'd0);
    check("rst_arready", {127'b0, bus.s_axi_arready}, 128'd1);
    check("rst_rd_en", {127'b0, bus.fifo_rd_en}, 128'd0);
    srst = 1'b0;
    @(posedge clk); #1;

    // DATA burst of four preloaded words, rready held high.
    for (int i = 1; i <= 4; i++) push(128'(i));
    beats.delete();
    p0 = pops;
    ar_req(6'h00, 8'd3);
    wait_beats(4, 20);
    for (int i = 0; i < 4; i++) begin
      check_beat(i, 128'(i + 1), 2'b00, (i == 3));
      if (i > 0 && i < beats.size())
        check("back_to_back", 128'(beats[i].cyc - beats[i-1].cyc), 128'd1);
    end
    wait_idle();
    check("data_pops", 128'(pops - p0), 128'd4);
    read_status(128'h0000_0004_0000_0001);

    // Same burst with rready toggling 1,0,0,1.
    for (int i = 5; i <= 8; i++) push(128'(i));
    beats.delete();
    p0 = pops;
    ar_req(6'h00, 8'd3);
    k = 0;
    while (beats.size() < 4 && k < 40) begin
      bus.s_axi_rready = pat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    bus.s_axi_rready = 1'b1;
    check("bp_beat_count", 128'(beats.size()), 128'd4);
    for (int i = 0; i < 4; i++) check_beat(i, 128'(i + 5), 2'b00, (i == 3));
    wait_idle();
    check("bp_pops", 128'(pops - p0), 128'd4);

    // Empty FIFO: the beat must wait (or time out when the timeout is built in).
    beats.delete();
    p0 = pops;
    ar_req(6'h00, 8'd0);
    c0 = cyc;
`ifdef FIFO2AXI_TIMEOUT_EN
    wait_beats(1, 40);
    check_beat(0, 128'd0, 2'b10, 1'b1);
    if (beats.size() > 0) check("tmo_delay", 128'(beats[0].cyc - c0), 128'd16);
    wait_idle();
    check("tmo_pops", 128'(pops - p0), 128'd0);
`else
    saw = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      saw = saw | bus.s_axi_rvalid;
    end
    check("stall_no_rvalid", {127'b0, saw}, 128'd0);
    push(128'hABCD);
    wait_beats(1, 10);
    check_beat(0, 128'hABCD, 2'b00, 1'b1);
    wait_idle();
    check("stall_pops", 128'(pops - p0), 128'd1);
    check("stall_cyc_unused", 128'(c0 > 0), 128'd1);
`endif

    // STATUS burst with FIFO flagged full and non-empty: two beats, no pop.
    push(128'h77);
    full_flag = 1'b1;
    beats.delete();
    p0 = pops;
    ar_req(6'h10, 8'd1);
    wait_beats(2, 10);
`ifdef FIFO2AXI_TIMEOUT_EN
    check_beat(0, 128'h0000_0008_0000_0002, 2'b00, 1'b0);
    check_beat(1, 128'h0000_0008_0000_0002, 2'b00, 1'b1);
`else
    check_beat(0, 128'h0000_0009_0000_0002, 2'b00, 1'b0);
    check_beat(1, 128'h0000_0009_0000_0002, 2'b00, 1'b1);
`endif
    wait_idle();
    check("status_pops", 128'(pops - p0), 128'd0);
    full_flag = 1'b0;

    // Unmapped address: three DECERR beats of zero.
    beats.delete();
    p0 = pops;
    ar_req(6'h20, 8'd2);
    wait_beats(3, 10);
    for (int i = 0; i < 3; i++) check_beat(i, 128'd0, 2'b11, (i == 2));
    wait_idle();
    check("decerr_pops", 128'(pops - p0), 128'd0);

    // Drain the leftover word so the next burst starts from a known head.
    beats.delete();
    ar_req(6'h00, 8'd0);
    wait_beats(1, 10);
    check_beat(0, 128'h77, 2'b00, 1'b1);
    wait_idle();

    // Reset during beat 2 of an eight-beat DATA burst.
    for (int i = 0; i < 8; i++) push(128'h100 + 128'(i));
    beats.delete();
    ar_req(6'h00, 8'd7);
    k = 0;
    while (!(bus.s_axi_rvalid && bus.s_axi_rdata == 128'h101) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_found_beat2", bus.s_axi_rdata, 128'h101);
    p0 = pops;
    srst = 1'b1;
    #1;
    check("rst_mid_rd_en", {127'b0, bus.fifo_rd_en}, 128'd0);
    @(posedge clk); #1;
    srst = 1'b0;
    check("rst_mid_rvalid", {127'b0, bus.s_axi_rvalid}, 128'd0);
    check("rst_mid_arready", {127'b0, bus.s_axi_arready}, 128'd1);
    check("rst_mid_pops", 128'(pops - p0), 128'd0);
    beats.delete();
    ar_req(6'h00, 8'd0);
    wait_beats(1, 10);
    check_beat(0, 128'h102, 2'b00, 1'b1);
    wait_idle();
    read_status(128'h0000_0001_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
